// File: rtl/idct_block_collector.sv
// idct_block_collector: captures 8x8 idct output blocks into a ping-pong
// pixel buffer and streams them out in capture order over valid/ready.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   done, din               idct output strobe and sample
//   pix_out, pix_valid      pixel stream out
//   pix_ready               downstream accept
//   blk_start               marks pixel 0 of each block
//   blk_count               fully drained blocks (16-bit, wraps)
//   overflow, short_blk     sticky error flags
//
// Options: define IDCT_PIX_SAT_EN to clamp out-of-range samples
// instead of truncating them.
module idct_block_collector #(
  parameter int DIN_W = 32,
  parameter int LSB   = 13,
  parameter int PIX_W = 8,
  parameter int BLK   = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             done,
  input  logic [DIN_W-1:0] din,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             blk_start,
  output logic [15:0]      blk_count,
  output logic             overflow,
  output logic             short_blk
);

  // BLK is a power of two so {bank, idx} forms the buffer address.
  localparam int IW = $clog2(BLK);
  localparam int AW = IW + 1;

  typedef enum logic [1:0] {
    C_IDLE, C_FILL, C_WAIT, C_DROP
  } cap_t;

  typedef enum logic {
    R_IDLE, R_STREAM
  } rd_t;

  cap_t cstate;
  rd_t  rstate;

  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [IW-1:0] cap_cnt;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] rd_nxt;

  logic [PIX_W-1:0] mem [2*BLK];
  logic [PIX_W-1:0] pix_in;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          cap_last;
  logic          rd_last;
  logic          rd_done;
  logic [1:0]    fill_set;
  logic [1:0]    fill_clr;

  // Low fraction bits are never used; the parity keeps them tied off.
  logic unused_din;
  assign unused_din = ^din;

  function automatic logic [PIX_W-1:0] to_pix(
    input logic [DIN_W-1:0] d
  );
`ifdef IDCT_PIX_SAT_EN
    logic [DIN_W-1:0] hi;
    hi = d >> (LSB + PIX_W);
    if (d[DIN_W-1])
      to_pix = '0;
    else if (|hi)
      to_pix = '1;
    else
      to_pix = d[LSB+PIX_W-1:LSB];
`else
    to_pix = d[LSB+PIX_W-1:LSB];
`endif
  endfunction

  assign pix_in = to_pix(din);
  assign rd_nxt = rd_idx + 1'b1;
  assign rd_last = (rd_idx == IW'(BLK - 1));
  assign rd_done = (rstate == R_STREAM) && pix_ready && rd_last;

  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = {wr_bank, {IW{1'b0}}};
    cap_last = 1'b0;
    unique case (1'b1)
      (cstate == C_IDLE): begin
        wr_en = done && !full[wr_bank];
      end
      (cstate == C_FILL): begin
        wr_en    = done;
        wr_addr  = {wr_bank, cap_cnt};
        cap_last = done && (cap_cnt == IW'(BLK - 1));
      end
      default: ;
    endcase
  end

  always_comb begin
    fill_set = 2'b00;
    fill_clr = 2'b00;
    if (cap_last)
      fill_set[wr_bank] = 1'b1;
    if (rd_done)
      fill_clr[rd_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= pix_in;
  end

  // Capture side. A bank freed this cycle shows as full until next
  // cycle, so a capture starting now against it is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cstate    <= C_IDLE;
      wr_bank   <= 1'b0;
      cap_cnt   <= '0;
      full      <= 2'b00;
      overflow  <= 1'b0;
      short_blk <= 1'b0;
    end else begin
      full <= (full | fill_set) & ~fill_clr;
      unique case (cstate)
        C_IDLE: begin
          if (done) begin
            if (!full[wr_bank]) begin
              cap_cnt <= IW'(1);
              cstate  <= C_FILL;
            end else begin
              overflow <= 1'b1;
              cstate   <= C_DROP;
            end
          end
        end
        C_FILL: begin
          if (!done) begin
            short_blk <= 1'b1;
            cap_cnt   <= '0;
            cstate    <= C_IDLE;
          end else if (cap_last) begin
            wr_bank <= ~wr_bank;
            cap_cnt <= '0;
            cstate  <= C_WAIT;
          end else begin
            cap_cnt <= cap_cnt + 1'b1;
          end
        end
        C_WAIT, C_DROP: begin
          if (!done)
            cstate <= C_IDLE;
        end
      endcase
    end
  end

  // Read side. pix_out is loaded one step ahead so it is registered
  // and stays put while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rstate    <= R_IDLE;
      rd_bank   <= 1'b0;
      rd_idx    <= '0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
      blk_start <= 1'b0;
      blk_count <= '0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (full[rd_bank]) begin
            rstate    <= R_STREAM;
            rd_idx    <= '0;
            pix_out   <= mem[{rd_bank, {IW{1'b0}}}];
            pix_valid <= 1'b1;
            blk_start <= 1'b1;
          end
        end
        R_STREAM: begin
          if (pix_ready) begin
            if (rd_last) begin
              rstate    <= R_IDLE;
              rd_bank   <= ~rd_bank;
              rd_idx    <= '0;
              blk_count <= blk_count + 16'd1;
              pix_out   <= '0;
              pix_valid <= 1'b0;
              blk_start <= 1'b0;
            end else begin
              rd_idx    <= rd_nxt;
              pix_out   <= mem[{rd_bank, rd_nxt}];
              blk_start <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idct_block_collector.sv
// tb_idct_block_collector: directed stimulus with a block-level
// queue model checked on every cycle, plus literal spot checks.
module tb_idct_block_collector;

  logic        clk;
  logic        reset_n;
  logic        done;
  logic [31:0] din;
  logic [7:0]  pix_out;
  logic        pix_valid;
  logic        pix_ready;
  logic        blk_start;
  logic [15:0] blk_count;
  logic        overflow;
  logic        short_blk;

  idct_block_collector dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .done      (done),
    .din       (din),
    .pix_out   (pix_out),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .blk_start (blk_start),
    .blk_count (blk_count),
    .overflow  (overflow),
    .short_blk (short_blk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] px(input logic [31:0] d);
`ifdef IDCT_PIX_SAT_EN
    if (d[31]) return 8'd0;
    if (d[30:21] != 0) return 8'd255;
    return d[20:13];
`else
    return d[20:13];
`endif
  endfunction

  // Model: completed blocks waiting to drain, as flat pixels plus
  // the first cycle each block may be shown.
  logic [7:0] pix_q[$];
  logic [7:0] run_buf[$];
  longint     start_q[$];
  logic [7:0] got[$];
  int         head_idx;
  int         run_cnt;
  bit         run_ok;
  bit         prev_done;
  bit         m_ovf;
  bit         m_short;
  logic [15:0] m_cnt;
  longint     cyc = 0;
  bit         exp_v;

  always @(negedge clk) begin
    if (!reset_n) begin
      pix_q.delete();
      run_buf.delete();
      start_q.delete();
      head_idx  = 0;
      run_cnt   = 0;
      run_ok    = 0;
      prev_done = 0;
      m_ovf     = 0;
      m_short   = 0;
      m_cnt     = 0;
    end else begin
      exp_v = (start_q.size() > 0) && (cyc >= start_q[0]);
      chk("pix_valid", pix_valid, exp_v);
      if (exp_v) begin
        chk("pix_out", pix_out, pix_q[0]);
        chk("blk_start", blk_start, head_idx == 0);
      end else begin
        chk("blk_start_idle", blk_start, 0);
      end
      chk("blk_count", blk_count, m_cnt);
      chk("overflow", overflow, m_ovf);
      chk("short_blk", short_blk, m_short);
      // capture decision sees occupancy before any free this cycle
      if (done) begin
        if (!prev_done) begin
          run_ok  = start_q.size() < 2;
          run_cnt = 0;
          run_buf.delete();
          if (!run_ok) m_ovf = 1;
        end
        if (run_ok && run_cnt < 64) begin
          run_buf.push_back(px(din));
          run_cnt++;
          if (run_cnt == 64) begin
            foreach (run_buf[i]) pix_q.push_back(run_buf[i]);
            start_q.push_back(cyc + 2);
          end
        end
      end else if (prev_done && run_ok && run_cnt < 64) begin
        m_short = 1;
      end
      prev_done = done;
      if (exp_v && pix_ready) begin
        got.push_back(pix_out);
        void'(pix_q.pop_front());
        head_idx++;
        if (head_idx == 64) begin
          head_idx = 0;
          void'(start_q.pop_front());
          m_cnt++;
          if (start_q.size() > 0 && start_q[0] < cyc + 2)
            start_q[0] = cyc + 2;
        end
      end
      cyc++;
    end
  end

  logic [31:0] tab [64];

  task automatic fill_tab(input int base);
    for (int k = 0; k < 64; k++)
      tab[k] = 32'((base + k) & 255) << 13;
  endtask

  task automatic send_tab(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      done = 1'b1;
      din  = tab[i];
    end
    @(posedge clk); #1;
    done = 1'b0;
    din  = '0;
  endtask

  task automatic wait_drain(input bit toggle, input int limit);
    int n = 0;
    while (start_q.size() > 0 && n < limit) begin
      @(posedge clk); #1;
      if (toggle) pix_ready = ~pix_ready;
      n++;
    end
    chk("drain_timeout", start_q.size(), 0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    done    = 1'b0;
    din     = '0;
    #1;
    chk("rst_pix_out", pix_out, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_blk_start", blk_start, 0);
    chk("rst_blk_count", blk_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_short_blk", short_blk, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    got.delete();
  endtask

  initial begin
    int n;
    reset_n   = 1'b1;
    done      = 1'b0;
    din       = '0;
    pix_ready = 1'b0;
    #2;
    apply_reset();

    // 1: plain block, ready high
    pix_ready = 1'b1;
    fill_tab(0);
    send_tab(64);
    chk("t1_lat1", pix_valid, 0);
    @(posedge clk); #1;
    chk("t1_lat2", pix_valid, 1);
    chk("t1_first", pix_out, 0);
    chk("t1_start", blk_start, 1);
    wait_drain(0, 200);
    chk("t1_n", got.size(), 64);
    chk("t1_p5", got[5], 5);
    chk("t1_p63", got[63], 63);
    chk("t1_cnt", blk_count, 1);

    // 2: both banks fill, third block dropped
    @(posedge clk); #2;
    apply_reset();
    pix_ready = 1'b0;
    fill_tab(8'h10); send_tab(64);
    fill_tab(8'h50); send_tab(64);
    fill_tab(8'h90); send_tab(64);
    @(posedge clk); #1;
    chk("t2_ovf", overflow, 1);
    pix_ready = 1'b1;
    wait_drain(0, 400);
    chk("t2_n", got.size(), 128);
    chk("t2_b0", got[0], 8'h10);
    chk("t2_b1", got[64], 8'h50);
    chk("t2_cnt", blk_count, 2);

    // 3: short block, then a good one
    @(posedge clk); #2;
    apply_reset();
    pix_ready = 1'b1;
    fill_tab(0);
    send_tab(40);
    @(posedge clk); #1;
    chk("t3_short", short_blk, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_novalid", pix_valid, 0);
    send_tab(64);
    wait_drain(0, 200);
    chk("t3_n", got.size(), 64);
    chk("t3_cnt", blk_count, 1);

    // 4: out-of-range samples
    @(posedge clk); #2;
    apply_reset();
    fill_tab(0);
    tab[0] = 32'hFFFF_E000;
    tab[1] = 32'h0020_0000;
    send_tab(64);
    wait_drain(0, 200);
`ifdef IDCT_PIX_SAT_EN
    chk("t4_neg", got[0], 0);
    chk("t4_big", got[1], 255);
`else
    chk("t4_neg", got[0], 8'hFF);
    chk("t4_big", got[1], 8'h00);
`endif

    // 6: ready toggling
    @(posedge clk); #2;
    apply_reset();
    pix_ready = 1'b0;
    fill_tab(8'h21);
    send_tab(64);
    wait_drain(1, 400);
    chk("t6_n", got.size(), 64);
    chk("t6_p63", got[63], 8'h60);

    // 5: reset mid-stream
    @(posedge clk); #2;
    apply_reset();
    pix_ready = 1'b1;
    fill_tab(0);
    send_tab(64);
    n = 0;
    while (got.size() < 30 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("t5_reach30", got.size(), 30);
    #1;
    apply_reset();
    send_tab(64);
    wait_drain(0, 200);
    chk("t5_n", got.size(), 64);
    chk("t5_p0", got[0], 0);
    chk("t5_cnt", blk_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
